// File: rtl/wb_trace_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_checker_pkg
// Description : Shared types and width helpers for the writeback trace checker.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_trace_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE       = 2'd0,
        FC_MISMATCH   = 2'd1,
        FC_UNEXP_REG  = 2'd2,
        FC_TIMEOUT    = 2'd3
    } fail_code_t;

    // Never returns 0 so single-entry configurations still get a 1-bit field.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_width(input int n);
        return addr_width(n + 1);
    endfunction

endpackage : wb_trace_checker_pkg
`default_nettype wire

// File: rtl/wb_exp_table.sv
`default_nettype none
// ============================================================================
// Module      : wb_exp_table
// Description : Expected (register, value) table; synchronous write,
//               asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_exp_table #(
    parameter int DEPTH      = 32,
    parameter int REG_AW     = 3,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 5
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [REG_AW-1:0]     i_wreg,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [REG_AW-1:0]     o_rreg,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [REG_AW+DATA_WIDTH-1:0] r_mem [DEPTH];

    // Contents survive reset so a run can be repeated without reloading.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= {i_wreg, i_wdata};
        end
    end

    assign {o_rreg, o_rdata} = r_mem[i_raddr];

endmodule : wb_exp_table
`default_nettype wire

// File: rtl/wb_trace_checker.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_checker
// Description : Compares retired register writes against an ordered table of
//               expected (register, value) pairs with timeout and fail capture.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trace_checker
    import wb_trace_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 8,
    parameter int PC_WIDTH   = 8,
    parameter int DEPTH      = 32,
    parameter int TIMEOUT    = 64,
    parameter int STRICT     = 0,
    parameter int REG_AW     = addr_width(REG_COUNT),
    parameter int IDX_W      = addr_width(DEPTH),
    parameter int CNT_W      = count_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tbl_we,
    input  logic [IDX_W-1:0]      tbl_addr,
    input  logic [REG_AW-1:0]     tbl_reg,
    input  logic [DATA_WIDTH-1:0] tbl_data,
    input  logic [CNT_W-1:0]      num_entries,
    input  logic                  start,
    input  logic                  wb_valid,
    input  logic [REG_AW-1:0]     wb_reg,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [PC_WIDTH-1:0]   pc,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [1:0]            fail_code,
    output logic [IDX_W-1:0]      fail_index,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [PC_WIDTH-1:0]   fail_pc,
    output logic [CNT_W-1:0]      check_count
);

    localparam int TMR_W = addr_width(TIMEOUT);
    localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] c_tmr_one  = TMR_W'(1);
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_index;
    logic [TMR_W-1:0]        r_timer;
    logic [CNT_W-1:0]        r_num;
    logic [CNT_W-1:0]        r_check_count;
    fail_code_t              r_fail_code;
    logic [IDX_W-1:0]        r_fail_index;
    logic [DATA_WIDTH-1:0]   r_fail_data;
    logic [PC_WIDTH-1:0]     r_fail_pc;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;

    logic                    w_tbl_we;
    logic [REG_AW-1:0]       w_exp_reg;
    logic [DATA_WIDTH-1:0]   w_exp_data;
    logic                    w_match;
    logic                    w_last;
    logic                    w_fail;
    fail_code_t              w_fail_code;
    logic [DATA_WIDTH-1:0]   w_fail_data;

    // The table is frozen while a run is in progress.
    assign w_tbl_we = tbl_we && (r_state != ST_RUN);

    wb_exp_table #(
        .DEPTH      (DEPTH),
        .REG_AW     (REG_AW),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk     (clock),
        .i_we    (w_tbl_we),
        .i_waddr (tbl_addr),
        .i_wreg  (tbl_reg),
        .i_wdata (tbl_data),
        .i_raddr (r_index),
        .o_rreg  (w_exp_reg),
        .o_rdata (w_exp_data)
    );

    always_comb begin
        w_match     = wb_valid && (wb_reg == w_exp_reg) && (wb_data == w_exp_data);
        w_last      = ((r_check_count + c_cnt_one) == r_num);
        w_fail      = 1'b0;
        w_fail_code = FC_NONE;
        w_fail_data = '0;
        // A non-strict foreign write falls through, so it still ages the timer.
        if (!w_match) begin
            if (wb_valid && (wb_reg == w_exp_reg)) begin
                w_fail      = 1'b1;
                w_fail_code = FC_MISMATCH;
                w_fail_data = wb_data;
            end else if (wb_valid && (STRICT != 0)) begin
                w_fail      = 1'b1;
                w_fail_code = FC_UNEXP_REG;
                w_fail_data = wb_data;
            end else if (r_timer == c_tmr_last) begin
                w_fail      = 1'b1;
                w_fail_code = FC_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_timer       <= '0;
            r_num         <= '0;
            r_check_count <= '0;
            r_fail_code   <= FC_NONE;
            r_fail_index  <= '0;
            r_fail_data   <= '0;
            r_fail_pc     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_match) begin
                        r_index       <= r_index + c_idx_one;
                        r_check_count <= r_check_count + c_cnt_one;
                        r_timer       <= '0;
                        if (w_last) begin
                            r_state <= ST_PASS;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end
                    end else if (w_fail) begin
                        r_state      <= ST_FAIL;
                        r_fail_code  <= w_fail_code;
                        r_fail_index <= r_index;
                        r_fail_data  <= w_fail_data;
                        r_fail_pc    <= pc;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_pass       <= 1'b0;
                    end else begin
                        r_timer <= r_timer + c_tmr_one;
                    end
                end
                default: begin
                    if (start) begin
                        r_num         <= num_entries;
                        r_index       <= '0;
                        r_timer       <= '0;
                        r_check_count <= '0;
                        r_fail_code   <= FC_NONE;
                        r_fail_index  <= '0;
                        r_fail_data   <= '0;
                        r_fail_pc     <= '0;
                        if (num_entries == '0) begin
                            r_state <= ST_PASS;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_code   = r_fail_code;
    assign fail_index  = r_fail_index;
    assign fail_data   = r_fail_data;
    assign fail_pc     = r_fail_pc;
    assign check_count = r_check_count;

endmodule : wb_trace_checker
`default_nettype wire

// File: tb/tb_wb_trace_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_trace_checker
// Description : Scoreboard bench for wb_trace_checker (non-strict and strict).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_trace_checker;

    localparam int DW  = 16;
    localparam int PW  = 8;
    localparam int IW  = 5;
    localparam int CW  = 6;
    localparam int RAW = 3;

    localparam int K_COUNT = 0;
    localparam int K_DONE  = 1;
    localparam int K_IDLE  = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           reset;
    logic           tbl_we;
    logic [IW-1:0]  tbl_addr;
    logic [RAW-1:0] tbl_reg;
    logic [DW-1:0]  tbl_data;
    logic [CW-1:0]  num_entries;
    logic           start;
    logic           wb_valid;
    logic [RAW-1:0] wb_reg;
    logic [DW-1:0]  wb_data;
    logic [PW-1:0]  pc;

    logic a_busy, a_done, a_pass, b_busy, b_done, b_pass;
    logic [1:0]    a_code, b_code;
    logic [IW-1:0] a_idx, b_idx;
    logic [DW-1:0] a_data, b_data;
    logic [PW-1:0] a_pc, b_pc;
    logic [CW-1:0] a_cnt, b_cnt;

    wb_trace_checker #(.DATA_WIDTH(DW), .REG_COUNT(8), .PC_WIDTH(PW), .DEPTH(32),
                       .TIMEOUT(64), .STRICT(0)) dut (
        .clock(clock), .reset(reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_reg(tbl_reg), .tbl_data(tbl_data), .num_entries(num_entries),
        .start(start), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .pc(pc), .busy(a_busy), .done(a_done), .pass(a_pass), .fail_code(a_code),
        .fail_index(a_idx), .fail_data(a_data), .fail_pc(a_pc), .check_count(a_cnt)
    );

    wb_trace_checker #(.DATA_WIDTH(DW), .REG_COUNT(8), .PC_WIDTH(PW), .DEPTH(32),
                       .TIMEOUT(64), .STRICT(1)) dut_s (
        .clock(clock), .reset(reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_reg(tbl_reg), .tbl_data(tbl_data), .num_entries(num_entries),
        .start(start), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .pc(pc), .busy(b_busy), .done(b_done), .pass(b_pass), .fail_code(b_code),
        .fail_index(b_idx), .fail_data(b_data), .fail_pc(b_pc), .check_count(b_cnt)
    );

    // Monitored instance: 0 = non-strict, 1 = strict.
    logic          sel = 1'b0;
    logic          m_busy, m_done, m_pass;
    logic [1:0]    m_code;
    logic [IW-1:0] m_idx;
    logic [DW-1:0] m_data;
    logic [PW-1:0] m_pc;
    logic [CW-1:0] m_cnt;
    assign m_busy = sel ? b_busy : a_busy;
    assign m_done = sel ? b_done : a_done;
    assign m_pass = sel ? b_pass : a_pass;
    assign m_code = sel ? b_code : a_code;
    assign m_idx  = sel ? b_idx  : a_idx;
    assign m_data = sel ? b_data : a_data;
    assign m_pc   = sel ? b_pc   : a_pc;
    assign m_cnt  = sel ? b_cnt  : a_cnt;

    typedef struct {
        string         name;
        int            kind;
        int            cyc;
        logic          done;
        logic          pass;
        logic [1:0]    code;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic [PW-1:0] pc;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_event(input int kind);
        exp_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: got event kind=%0d at cycle %0d, expected none", kind, cyc);
            return;
        end
        e = q.pop_front();
        if (e.kind != kind) begin
            n_errors++;
            $display("FAIL %s: got event kind=%0d at cycle %0d, expected kind=%0d at cycle %0d",
                     e.name, kind, cyc, e.kind, e.cyc);
        end else if (kind == K_COUNT) begin
            if (cyc != e.cyc || m_cnt != e.cnt) begin
                n_errors++;
                $display("FAIL %s: got cnt=%0d at cycle %0d, expected cnt=%0d at cycle %0d",
                         e.name, m_cnt, cyc, e.cnt, e.cyc);
            end
        end else begin
            if (cyc != e.cyc || m_busy != 1'b0 || m_done != e.done || m_pass != e.pass ||
                m_code != e.code || m_idx != e.idx || m_data != e.data ||
                m_pc != e.pc || m_cnt != e.cnt) begin
                n_errors++;
                $display("FAIL %s: got cyc=%0d busy=%0b done=%0b pass=%0b code=%0d idx=%0d data=%0d pc=%0h cnt=%0d, expected cyc=%0d busy=0 done=%0b pass=%0b code=%0d idx=%0d data=%0d pc=%0h cnt=%0d",
                         e.name, cyc, m_busy, m_done, m_pass, m_code, m_idx, m_data, m_pc, m_cnt,
                         e.cyc, e.done, e.pass, e.code, e.idx, e.data, e.pc, e.cnt);
            end
        end
    endtask

    logic          prev_busy = 1'b0;
    logic          prev_done = 1'b0;
    logic [CW-1:0] prev_cnt  = '0;

    always @(negedge clock) begin
        if (m_cnt != prev_cnt && m_cnt != '0) check_event(K_COUNT);
        if (m_done && !prev_done)             check_event(K_DONE);
        if (!m_busy && prev_busy && !m_done)  check_event(K_IDLE);
        prev_busy <= m_busy;
        prev_done <= m_done;
        prev_cnt  <= m_cnt;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_cnt(input string nm, input int c, input int at);
        exp_t e;
        e.name = nm; e.kind = K_COUNT; e.cyc = at; e.done = 1'b0; e.pass = 1'b0;
        e.code = '0; e.idx = '0; e.data = '0; e.pc = '0; e.cnt = CW'(c);
        q.push_back(e);
    endtask

    task automatic push_end(input string nm, input int kind, input int at, input int ps,
                            input int code, input int idx, input int data, input int p,
                            input int c);
        exp_t e;
        e.name = nm; e.kind = kind; e.cyc = at; e.done = (kind == K_DONE);
        e.pass = (ps != 0); e.code = 2'(code); e.idx = IW'(idx); e.data = DW'(data);
        e.pc = PW'(p); e.cnt = CW'(c);
        q.push_back(e);
    endtask

    task automatic load(input int a, input int r, input int d);
        tbl_we = 1'b1; tbl_addr = IW'(a); tbl_reg = RAW'(r); tbl_data = DW'(d);
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic start_run(input int n, output int t);
        num_entries = CW'(n); start = 1'b1; t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wb(input int r, input int d, input int p);
        wb_valid = 1'b1; wb_reg = RAW'(r); wb_data = DW'(d); pc = PW'(p);
        tick();
        wb_valid = 1'b0;
    endtask

    // Drive one expected-match write and predict the count step (and PASS on the last).
    task automatic wb_ok(input string nm, input int d, input int c, input int last);
        push_cnt(nm, c, cyc + 1);
        if (last != 0) push_end({nm, "_pass"}, K_DONE, cyc + 1, 1, 0, 0, 0, 0, c);
        wb(7, d, c);
    endtask

    task automatic do_reset(input logic new_sel);
        reset = 1'b0;
        tick();
        sel = new_sel;
        tick();
        reset = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no event by cycle %0d, expected one at cycle %0d", e.name, cyc, e.cyc);
        end
        tick();
    endtask

    int t;
    int vals[4] = '{6, 1, 15, 9};

    initial begin
        reset = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_reg = '0; tbl_data = '0;
        num_entries = '0; start = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0; pc = '0;
        repeat (3) tick();

        n_checks += 2;
        if ({a_busy, a_done, a_pass, a_code, a_idx, a_data, a_pc, a_cnt} != '0) begin
            n_errors++;
            $display("FAIL reset_state_nonstrict: got busy=%0b done=%0b pass=%0b cnt=%0d, expected all zero",
                     a_busy, a_done, a_pass, a_cnt);
        end
        if ({b_busy, b_done, b_pass, b_code, b_idx, b_data, b_pc, b_cnt} != '0) begin
            n_errors++;
            $display("FAIL reset_state_strict: got busy=%0b done=%0b pass=%0b cnt=%0d, expected all zero",
                     b_busy, b_done, b_pass, b_cnt);
        end
        reset = 1'b1;

        for (int i = 0; i < 4; i++) load(i, 7, vals[i]);

        // Basic pass, writes three cycles apart.
        start_run(4, t);
        for (int i = 0; i < 4; i++) begin
            wb_ok("basic_cnt", vals[i], i + 1, (i == 3) ? 1 : 0);
            tick(); tick();
        end
        drain(50);

        // Data error on the third entry.
        start_run(4, t);
        wb_ok("mism_cnt", 6, 1, 0);
        wb_ok("mism_cnt", 1, 2, 0);
        push_end("mism_fail", K_DONE, cyc + 1, 0, 1, 2, 14, 8'h0A, 2);
        wb(7, 14, 8'h0A);
        drain(50);

        // Non-strict: foreign R3 writes are ignored.
        start_run(4, t);
        wb(3, 6, 1);
        wb_ok("nonstrict_cnt", 6, 1, 0);
        wb(3, 1, 2);
        wb_ok("nonstrict_cnt", 1, 2, 0);
        wb(3, 9, 3);
        wb_ok("nonstrict_cnt", 15, 3, 0);
        wb(3, 15, 4);
        wb_ok("nonstrict_cnt", 9, 4, 1);
        drain(50);

        // Strict: a single R3 write fails.
        do_reset(1'b1);
        start_run(4, t);
        wb_ok("strict_cnt", 6, 1, 0);
        push_end("strict_fail", K_DONE, cyc + 1, 0, 2, 1, 1, 8'h21, 1);
        wb(3, 1, 8'h21);
        drain(50);
        do_reset(1'b0);

        // Timeout exactly 64 cycles after start.
        pc = 8'h33;
        start_run(1, t);
        push_end("timeout_fail", K_DONE, t + 65, 0, 3, 0, 0, 8'h33, 0);
        drain(100);

        // Match on the timeout cycle wins.
        start_run(1, t);
        repeat (63) tick();
        wb_ok("edge_match", 6, 1, 1);
        drain(20);

        // Zero-entry run passes on the next cycle.
        do_reset(1'b0);
        start_run(0, t);
        push_end("zero_entries", K_DONE, t + 1, 1, 0, 0, 0, 0, 0);
        drain(20);

        // Reset mid-run, then rerun on the retained table.
        do_reset(1'b0);
        start_run(4, t);
        wb_ok("abort_cnt", 6, 1, 0);
        tick();
        wb_ok("abort_cnt", 1, 2, 0);
        tick();
        reset = 1'b0;
        push_end("abort_idle", K_IDLE, cyc + 1, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        drain(20);
        start_run(4, t);
        for (int i = 0; i < 4; i++) wb_ok("rerun_cnt", vals[i], i + 1, (i == 3) ? 1 : 0);
        drain(20);

        // Table write during a run is ignored: 99 on entry 3 still fails.
        start_run(4, t);
        load(3, 7, 99);
        wb_ok("frozen_cnt", 6, 1, 0);
        wb_ok("frozen_cnt", 1, 2, 0);
        wb_ok("frozen_cnt", 15, 3, 0);
        push_end("frozen_fail", K_DONE, cyc + 1, 0, 1, 3, 99, 8'h44, 3);
        wb(7, 99, 8'h44);
        drain(50);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_wb_trace_checker
`default_nettype wire
